// File: rtl/anita4_pol_coinc_scaler.sv
// anita4_pol_coinc_scaler: H/V single edge detect, latch clear, windowed
// coincidence and per-period scalers. Option macro: ANITA4_SCAL_SATURATE_EN.
module anita4_pol_coinc_scaler #(
    parameter int NCH     = 4,
    parameter int WIN     = 4,
    parameter int CLR_CYC = 2,
    parameter int PERIOD  = 1000,
    parameter int SCAL_W  = 16
) (
    input  logic              CLK,
    input  logic              CLR_N,
    input  logic [NCH-1:0]    SYNC_H,
    input  logic [NCH-1:0]    SYNC_V,
    input  logic [NCH-1:0]    MASK_H,
    input  logic [NCH-1:0]    MASK_V,
    output logic [NCH-1:0]    LATCH_CLR_H,
    output logic [NCH-1:0]    LATCH_CLR_V,
    output logic [NCH-1:0]    COINC,
    input  logic [7:0]        SCAL_SEL,
    output logic [SCAL_W-1:0] SCAL_DATA,
    output logic              SCAL_DONE
);

    localparam int NSC = 3 * NCH;
    localparam int PW  = $clog2(PERIOD);
`ifdef ANITA4_SCAL_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic [NCH-1:0]             sh_q, sh_d, sv_q, sv_d;
    logic [NCH-1:0][2:0]        clrh_q, clrh_d, clrv_q, clrv_d;
    logic [NCH-1:0][3:0]        winh_q, winh_d, winv_q, winv_d;
    logic [NCH-1:0]             coinc_q, coinc_d;
    logic [NSC-1:0][SCAL_W-1:0] cnt_q, cnt_d, hold_q, hold_d;
    logic [PW-1:0]              per_q, per_d;
    logic                       done_q, done_d;
    logic [SCAL_W-1:0]          data_q, data_d;
    logic [NCH-1:0]             ev_h, ev_v, uh, uv;
    logic [NSC-1:0]             inc;
    logic                       term;

    always_comb begin
        sh_d    = SYNC_H;
        sv_d    = SYNC_V;
        ev_h    = SYNC_H & ~sh_q;
        ev_v    = SYNC_V & ~sv_q;
        uh      = ev_h & ~MASK_H;
        uv      = ev_v & ~MASK_V;
        term    = (per_q == PW'(PERIOD - 1));
        clrh_d  = clrh_q;
        clrv_d  = clrv_q;
        winh_d  = winh_q;
        winv_d  = winv_q;
        coinc_d = '0;
        for (int i = 0; i < NCH; i++) begin
            // Clear pulse: any edge (masked or not) restarts the count
            if (ev_h[i])
                clrh_d[i] = 3'(CLR_CYC);
            else if (clrh_q[i] != 3'd0)
                clrh_d[i] = clrh_q[i] - 3'd1;
            if (ev_v[i])
                clrv_d[i] = 3'(CLR_CYC);
            else if (clrv_q[i] != 3'd0)
                clrv_d[i] = clrv_q[i] - 3'd1;

            coinc_d[i] = (uh[i] & uv[i])
                       | (uv[i] & (winh_q[i] != 4'd0))
                       | (uh[i] & (winv_q[i] != 4'd0));
            if (coinc_d[i]) begin
                winh_d[i] = 4'd0;
                winv_d[i] = 4'd0;
            end else begin
                if (uh[i])
                    winh_d[i] = 4'(WIN);
                else if (winh_q[i] != 4'd0)
                    winh_d[i] = winh_q[i] - 4'd1;
                if (uv[i])
                    winv_d[i] = 4'(WIN);
                else if (winv_q[i] != 4'd0)
                    winv_d[i] = winv_q[i] - 4'd1;
            end
        end
    end

    always_comb begin
        inc    = {coinc_d, uv, uh};
        cnt_d  = cnt_q;
        hold_d = hold_q;
        for (int k = 0; k < NSC; k++) begin
            // Terminal-cycle increments belong to the new period
            if (term) begin
                hold_d[k] = cnt_q[k];
                cnt_d[k]  = SCAL_W'(inc[k]);
            end else if (inc[k] && !(SAT && cnt_q[k] == '1)) begin
                cnt_d[k]  = cnt_q[k] + SCAL_W'(1);
            end
        end
        per_d  = term ? '0 : per_q + PW'(1);
        done_d = term;
        data_d = '0;
        for (int k = 0; k < NSC; k++) begin
            if (SCAL_SEL == 8'(k))
                data_d = hold_q[k];
        end
    end

    always_ff @(posedge CLK) begin
        if (!CLR_N) begin
            sh_q    <= '0;
            sv_q    <= '0;
            clrh_q  <= '0;
            clrv_q  <= '0;
            winh_q  <= '0;
            winv_q  <= '0;
            coinc_q <= '0;
            cnt_q   <= '0;
            hold_q  <= '0;
            per_q   <= '0;
            done_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            sh_q    <= sh_d;
            sv_q    <= sv_d;
            clrh_q  <= clrh_d;
            clrv_q  <= clrv_d;
            winh_q  <= winh_d;
            winv_q  <= winv_d;
            coinc_q <= coinc_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            per_q   <= per_d;
            done_q  <= done_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        LATCH_CLR_H = '0;
        LATCH_CLR_V = '0;
        for (int i = 0; i < NCH; i++) begin
            LATCH_CLR_H[i] = (clrh_q[i] != 3'd0);
            LATCH_CLR_V[i] = (clrv_q[i] != 3'd0);
        end
    end

    assign COINC     = coinc_q;
    assign SCAL_DATA = data_q;
    assign SCAL_DONE = done_q;

endmodule

// File: tb/tb_anita4_pol_coinc_scaler.sv
// tb_anita4_pol_coinc_scaler: scenario tasks with a queue scoreboard
// of expected scaler readouts for anita4_pol_coinc_scaler.
`timescale 1ns/1ps
module tb_anita4_pol_coinc_scaler;

    localparam int NCH     = 4;
    localparam int WIN     = 4;
    localparam int CLR_CYC = 2;
    localparam int PERIOD  = 100;
    localparam int SCAL_W  = 4;
    localparam int NSC     = 3 * NCH;

    logic              CLK = 1'b0;
    logic              CLR_N = 1'b0;
    logic [NCH-1:0]    SYNC_H = '0;
    logic [NCH-1:0]    SYNC_V = '0;
    logic [NCH-1:0]    MASK_H = '0;
    logic [NCH-1:0]    MASK_V = '0;
    logic [NCH-1:0]    LATCH_CLR_H;
    logic [NCH-1:0]    LATCH_CLR_V;
    logic [NCH-1:0]    COINC;
    logic [7:0]        SCAL_SEL = 8'd0;
    logic [SCAL_W-1:0] SCAL_DATA;
    logic              SCAL_DONE;

    always #5 CLK = ~CLK;

    anita4_pol_coinc_scaler #(
        .NCH(NCH), .WIN(WIN), .CLR_CYC(CLR_CYC),
        .PERIOD(PERIOD), .SCAL_W(SCAL_W)
    ) dut (
        .CLK(CLK), .CLR_N(CLR_N),
        .SYNC_H(SYNC_H), .SYNC_V(SYNC_V),
        .MASK_H(MASK_H), .MASK_V(MASK_V),
        .LATCH_CLR_H(LATCH_CLR_H), .LATCH_CLR_V(LATCH_CLR_V),
        .COINC(COINC), .SCAL_SEL(SCAL_SEL),
        .SCAL_DATA(SCAL_DATA), .SCAL_DONE(SCAL_DONE)
    );

    int n_chk  = 0;
    int n_fail = 0;
    logic [SCAL_W-1:0] expq[$];
    int exp_cnt[NSC];

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clear_exp();
        for (int k = 0; k < NSC; k++) exp_cnt[k] = 0;
    endtask

    // One readout set: NSC scalers, then index NSC and 255 which read 0
    task automatic push_exp();
        for (int k = 0; k < NSC; k++) expq.push_back(SCAL_W'(exp_cnt[k]));
        expq.push_back('0);
        expq.push_back('0);
    endtask

    task automatic readout(input string tag);
        logic [SCAL_W-1:0] e;
        for (int k = 0; k <= NSC + 1; k++) begin
            SCAL_SEL = (k == NSC + 1) ? 8'hFF : 8'(k);
            tick();
            n_chk++;
            if (expq.size() == 0) begin
                n_fail++;
                $display("FAIL %s sel=%0d: scoreboard empty", tag, SCAL_SEL);
            end else begin
                e = expq.pop_front();
                if (SCAL_DATA !== e) begin
                    n_fail++;
                    $display("FAIL %s sel=%0d: got %0d expected %0d", tag, SCAL_SEL, SCAL_DATA, e);
                end
            end
        end
        SCAL_SEL = 8'd0;
    endtask

    task automatic wait_done(input string tag);
        int t;
        t = 0;
        do begin
            tick();
            t++;
        end while (SCAL_DONE !== 1'b1 && t < 3 * PERIOD);
        if (SCAL_DONE !== 1'b1) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s: no SCAL_DONE within %0d cycles", tag, t);
        end
    endtask

    task automatic test_reset();
        int t;
        CLR_N = 1'b0;
        idle(3);
        n_chk++;
        if (LATCH_CLR_H !== '0) begin n_fail++; $display("FAIL reset clr_h: got %b expected 0", LATCH_CLR_H); end
        n_chk++;
        if (LATCH_CLR_V !== '0) begin n_fail++; $display("FAIL reset clr_v: got %b expected 0", LATCH_CLR_V); end
        n_chk++;
        if (COINC !== '0) begin n_fail++; $display("FAIL reset coinc: got %b expected 0", COINC); end
        n_chk++;
        if (SCAL_DATA !== '0) begin n_fail++; $display("FAIL reset data: got %0d expected 0", SCAL_DATA); end
        n_chk++;
        if (SCAL_DONE !== 1'b0) begin n_fail++; $display("FAIL reset done: got %b expected 0", SCAL_DONE); end
        CLR_N = 1'b1;
        t = 0;
        do begin
            tick();
            t++;
        end while (SCAL_DONE !== 1'b1 && t < 3 * PERIOD);
        n_chk++;
        if (t != PERIOD) begin n_fail++; $display("FAIL reset first_period: got %0d expected %0d", t, PERIOD); end
        tick();
        n_chk++;
        if (SCAL_DONE !== 1'b0) begin n_fail++; $display("FAIL done_width: got %b expected 0", SCAL_DONE); end
    endtask

    task automatic test_single_h();
        logic seen;
        wait_done("single_h start");
        clear_exp();
        SYNC_H[0] = 1'b1;
        tick();
        n_chk++;
        if (LATCH_CLR_H !== 4'b0001) begin n_fail++; $display("FAIL single clr_h c1: got %b expected 0001", LATCH_CLR_H); end
        n_chk++;
        if (LATCH_CLR_V !== 4'b0000) begin n_fail++; $display("FAIL single clr_v c1: got %b expected 0000", LATCH_CLR_V); end
        tick();
        n_chk++;
        if (LATCH_CLR_H !== 4'b0001) begin n_fail++; $display("FAIL single clr_h c2: got %b expected 0001", LATCH_CLR_H); end
        tick();
        n_chk++;
        if (LATCH_CLR_H !== 4'b0000) begin n_fail++; $display("FAIL single clr_h c3: got %b expected 0000", LATCH_CLR_H); end
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            seen = seen | (COINC != '0) | (LATCH_CLR_H != '0);
        end
        n_chk++;
        if (seen !== 1'b0) begin n_fail++; $display("FAIL single quiet: got activity=%b expected 0", seen); end
        SYNC_H[0] = 1'b0;
        exp_cnt[0] = 1;
        push_exp();
        wait_done("single_h end");
        readout("single_h");
    endtask

    task automatic test_window();
        wait_done("window start");
        clear_exp();
        SYNC_H[0] = 1'b1;
        tick();
        n_chk++;
        if (COINC !== 4'b0000) begin n_fail++; $display("FAIL win4 early: got %b expected 0000", COINC); end
        idle(3);
        SYNC_V[0] = 1'b1;
        tick();
        n_chk++;
        if (COINC !== 4'b0001) begin n_fail++; $display("FAIL win4 coinc: got %b expected 0001", COINC); end
        tick();
        n_chk++;
        if (COINC !== 4'b0000) begin n_fail++; $display("FAIL win4 width: got %b expected 0000", COINC); end
        SYNC_H = '0;
        SYNC_V = '0;
        idle(2);
        SYNC_H[0] = 1'b1;
        tick();
        idle(4);
        SYNC_V[0] = 1'b1;
        tick();
        n_chk++;
        if (COINC !== 4'b0000) begin n_fail++; $display("FAIL win5 none: got %b expected 0000", COINC); end
        tick();
        n_chk++;
        if (COINC !== 4'b0000) begin n_fail++; $display("FAIL win5 late: got %b expected 0000", COINC); end
        SYNC_H = '0;
        SYNC_V = '0;
        idle(8);
        SYNC_H[0] = 1'b1;
        SYNC_V[0] = 1'b1;
        tick();
        n_chk++;
        if (COINC !== 4'b0001) begin n_fail++; $display("FAIL same_cycle: got %b expected 0001", COINC); end
        tick();
        n_chk++;
        if (COINC !== 4'b0000) begin n_fail++; $display("FAIL same_width: got %b expected 0000", COINC); end
        SYNC_H = '0;
        SYNC_V = '0;
        idle(2);
        SYNC_V[2] = 1'b1;
        tick();
        tick();
        SYNC_H[2] = 1'b1;
        tick();
        n_chk++;
        if (COINC !== 4'b0100) begin n_fail++; $display("FAIL v_then_h: got %b expected 0100", COINC); end
        tick();
        SYNC_H = '0;
        SYNC_V = '0;
        exp_cnt[0] = 3;
        exp_cnt[NCH] = 3;
        exp_cnt[2 * NCH] = 2;
        exp_cnt[2] = 1;
        exp_cnt[NCH + 2] = 1;
        exp_cnt[2 * NCH + 2] = 1;
        push_exp();
        wait_done("window end");
        readout("window");
    endtask

    task automatic test_masking();
        wait_done("mask start");
        clear_exp();
        MASK_V[1] = 1'b1;
        MASK_H[3] = 1'b1;
        for (int r = 0; r < 5; r++) begin
            SYNC_H = 4'b1010;
            SYNC_V = 4'b1010;
            tick();
            n_chk++;
            if (LATCH_CLR_V !== 4'b1010) begin n_fail++; $display("FAIL mask clr_v r%0d: got %b expected 1010", r, LATCH_CLR_V); end
            n_chk++;
            if (LATCH_CLR_H !== 4'b1010) begin n_fail++; $display("FAIL mask clr_h r%0d: got %b expected 1010", r, LATCH_CLR_H); end
            n_chk++;
            if (COINC !== 4'b0000) begin n_fail++; $display("FAIL mask coinc r%0d: got %b expected 0000", r, COINC); end
            tick();
            SYNC_H = '0;
            SYNC_V = '0;
            tick();
            n_chk++;
            if (LATCH_CLR_V !== 4'b0000) begin n_fail++; $display("FAIL mask clr_end r%0d: got %b expected 0000", r, LATCH_CLR_V); end
            tick();
        end
        MASK_V = '0;
        MASK_H = '0;
        exp_cnt[1] = 5;
        exp_cnt[NCH + 3] = 5;
        push_exp();
        wait_done("mask end");
        readout("mask");
    endtask

    task automatic test_period_boundary();
        wait_done("period start");
        clear_exp();
        exp_cnt[0] = 1;
        push_exp();
        for (int c = 0; c < PERIOD; c++) begin
            SYNC_H[0] = (c == 50 || c == PERIOD - 1);
            tick();
            if (c == PERIOD - 2) begin
                n_chk++;
                if (SCAL_DONE !== 1'b0) begin n_fail++; $display("FAIL done_early: got %b expected 0", SCAL_DONE); end
            end
        end
        n_chk++;
        if (SCAL_DONE !== 1'b1) begin n_fail++; $display("FAIL done_at_term: got %b expected 1", SCAL_DONE); end
        SYNC_H[0] = 1'b0;
        readout("period1");
        push_exp();
        wait_done("period2 end");
        readout("period2");
    endtask

    task automatic test_saturate_wrap();
        wait_done("sat start");
        clear_exp();
        for (int r = 0; r < 20; r++) begin
            SYNC_V[2] = 1'b1;
            tick();
            SYNC_V[2] = 1'b0;
            tick();
        end
`ifdef ANITA4_SCAL_SATURATE_EN
        exp_cnt[NCH + 2] = (1 << SCAL_W) - 1;
`else
        exp_cnt[NCH + 2] = 20 % (1 << SCAL_W);
`endif
        push_exp();
        wait_done("sat end");
        readout("sat_wrap");
    endtask

    task automatic test_mid_reset();
        int t;
        clear_exp();
        SYNC_H[0] = 1'b1;
        tick();
        n_chk++;
        if (LATCH_CLR_H !== 4'b0001) begin n_fail++; $display("FAIL mid clr_before: got %b expected 0001", LATCH_CLR_H); end
        CLR_N = 1'b0;
        tick();
        n_chk++;
        if (LATCH_CLR_H !== 4'b0000) begin n_fail++; $display("FAIL mid clr_abort: got %b expected 0000", LATCH_CLR_H); end
        SYNC_H[0] = 1'b0;
        idle(2);
        CLR_N = 1'b1;
        push_exp();
        readout("mid_reset zero");
        t = NSC + 2;
        do begin
            tick();
            t++;
        end while (SCAL_DONE !== 1'b1 && t < 3 * PERIOD);
        n_chk++;
        if (t != PERIOD) begin n_fail++; $display("FAIL mid done_delay: got %0d expected %0d", t, PERIOD); end
        push_exp();
        readout("mid_reset period");
    endtask

    initial begin
        test_reset();
        test_single_h();
        test_window();
        test_masking();
        test_period_boundary();
        test_saturate_wrap();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
